// File: rtl/jzjpcc_pkg.sv
// Shared types for the jzjpcc MMIO output block: register count, address width,
// the write-request bundle and the byte-merge helper used by the register file.
package jzjpcc_pkg;

  localparam int MMIO_COUNT  = 8;
  localparam int MMIO_ADDR_W = 3;
  localparam int MMIO_BYTES  = 4;

  typedef logic [31:0]            mmio_word_t;
  typedef logic [MMIO_ADDR_W-1:0] mmio_addr_t;
  typedef logic [MMIO_BYTES-1:0]  mmio_be_t;

  typedef struct packed {
    logic       req;
    mmio_addr_t addr;
    mmio_word_t wdata;
    mmio_be_t   byteEn;
  } mmio_req_t;

  // Bytes with a clear enable keep the old contents.
  function automatic mmio_word_t merge_bytes(input mmio_word_t old_word,
                                             input mmio_word_t new_word,
                                             input mmio_be_t   byte_en);
    mmio_word_t merged;
    merged = old_word;
    for (int b = 0; b < MMIO_BYTES; b++) begin
      if (byte_en[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/jzjpcc_mmio_regfile.sv
// Eight 32-bit MMIO registers with a single byte-enabled write port.
// Write lands on the rising edge and is visible the next cycle; reset clears all words.
module jzjpcc_mmio_regfile
  import jzjpcc_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  mmio_req_t  wr,
  output mmio_word_t regs [MMIO_COUNT]
);

  mmio_word_t mem [MMIO_COUNT];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MMIO_COUNT; i++) mem[i] <= '0;
    end else if (wr.req) begin
      mem[wr.addr] <= merge_bytes(mem[wr.addr], wr.wdata, wr.byteEn);
    end
  end

  assign regs = mem;

endmodule

// File: rtl/jzjpcc_mmio_arbiter.sv
// Core/host write arbiter for the MMIO output registers: combinational grant, data on pins next cycle.
// Core has priority; JZJPCC_MMIO_ARB_STARVE_GUARD_EN adds a wait counter that forces a host win.
module jzjpcc_mmio_arbiter
  import jzjpcc_pkg::*;
#(
  parameter int MAX_HOST_WAIT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       coreReq,
  input  mmio_addr_t coreAddr,
  input  mmio_word_t coreWData,
  input  mmio_be_t   coreByteEn,
  output logic       coreGnt,
  input  logic       hostReq,
  input  mmio_addr_t hostAddr,
  input  mmio_word_t hostWData,
  input  mmio_be_t   hostByteEn,
  output logic       hostGnt,
  output mmio_word_t mmioOutputs [MMIO_COUNT]
);

  if (MAX_HOST_WAIT < 1 || MAX_HOST_WAIT > 255) begin : g_bad_wait
    $error("MAX_HOST_WAIT must be within 1..255");
  end

  mmio_req_t core_bundle;
  mmio_req_t host_bundle;
  mmio_req_t wr_port;
  logic      force_host;

  assign core_bundle = {coreReq, coreAddr, coreWData, coreByteEn};
  assign host_bundle = {hostReq, hostAddr, hostWData, hostByteEn};

`ifdef JZJPCC_MMIO_ARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_HOST_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_HOST_WAIT);

  logic [WAIT_W-1:0] hostWait;

  // Counts consecutive refused cycles; a grant or a withdrawn request restarts it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hostWait <= '0;
    end else if (!hostReq || hostGnt) begin
      hostWait <= '0;
    end else if (hostWait != WAIT_MAX) begin
      hostWait <= hostWait + 1'b1;
    end
  end

  assign force_host = hostReq && (hostWait == WAIT_MAX);
`else
  assign force_host = 1'b0;
`endif

  assign hostGnt = hostReq && (!coreReq || force_host);
  assign coreGnt = coreReq && !hostGnt;

  // Only the winner's bundle reaches the register file.
  always_comb begin
    wr_port     = core_bundle;
    if (hostGnt) wr_port = host_bundle;
    wr_port.req = coreGnt || hostGnt;
  end

  jzjpcc_mmio_regfile u_regfile (
    .clock (clock),
    .reset (reset),
    .wr    (wr_port),
    .regs  (mmioOutputs)
  );

  always_ff @(posedge clock) begin
    if (!reset) assert (!(coreGnt && hostGnt));
  end

endmodule
